// File: rtl/cordic_gain_corrector.sv
// Scales raw sign-magnitude CORDIC x/y by the gain-compensation constant K
// using a bit-serial shift-add multiplier, returning rounded two's-complement cos/sin.
//
// state | meaning
// IDLE  | ready for a new x/y pair
// MUL   | one coefficient bit per cycle, LSB first, x and y in parallel
// FINAL | round, apply sign, saturate, register results
// HOLD  | result presented until out_ready
module cordic_gain_corrector #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int K_COEF = 2487
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] cos_out,
  output logic [DATA_W-1:0] sin_out,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int MAG_W = DATA_W - 1;
  localparam int ACC_W = MAG_W + COEF_W + 1;
  localparam int CNT_W = (COEF_W > 1) ? $clog2(COEF_W) : 1;

  localparam logic [COEF_W-1:0] K_BITS   = COEF_W'(K_COEF);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(COEF_W - 1);
  localparam logic [ACC_W-1:0]  RND_HALF = ACC_W'(1) << (COEF_W - 1);
  localparam logic [DATA_W-1:0] POS_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, FINAL, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sx_q, sx_d, sy_q, sy_d;
  logic [MAG_W-1:0]   mx_q, mx_d, my_q, my_d;
  logic [ACC_W-1:0]   accx_q, accx_d, accy_q, accy_d;
  logic [DATA_W-1:0]  cos_q, cos_d, sin_q, sin_d;
  logic               vld_q, vld_d;

  logic [CNT_W-1:0]   bit_idx;
  logic [ACC_W-1:0]   addx, addy;

  // Round half up, then restore the sign; a magnitude that rounds to zero stays +0.
  function automatic logic [DATA_W-1:0] finish(input logic sign, input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] rnd;
    logic [DATA_W-1:0] res;
    sum = acc + RND_HALF;
    rnd = sum[ACC_W-1:COEF_W];
    if (rnd == '0)
      res = '0;
    else if (!sign)
      res = (rnd > POS_MAX) ? POS_MAX : rnd;
    else
      res = (rnd > NEG_MIN) ? NEG_MIN : (~rnd + 1'b1);
    return res;
  endfunction

  assign bit_idx = CNT_LOAD - cnt_q;
  assign addx    = K_BITS[bit_idx] ? (ACC_W'(mx_q) << bit_idx) : '0;
  assign addy    = K_BITS[bit_idx] ? (ACC_W'(my_q) << bit_idx) : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    mx_d    = mx_q;
    my_d    = my_q;
    accx_d  = accx_q;
    accy_d  = accy_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    vld_d   = vld_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sx_d    = x_in[DATA_W-1];
          sy_d    = y_in[DATA_W-1];
          mx_d    = x_in[MAG_W-1:0];
          my_d    = y_in[MAG_W-1:0];
          accx_d  = '0;
          accy_d  = '0;
          cnt_d   = CNT_LOAD;
          state_d = MUL;
        end
      end
      MUL: begin
        accx_d = accx_q + addx;
        accy_d = accy_q + addy;
        if (cnt_q == '0)
          state_d = FINAL;
        else
          cnt_d = cnt_q - 1'b1;
      end
      FINAL: begin
        cos_d   = finish(sx_q, accx_q);
        sin_d   = finish(sy_q, accy_q);
        vld_d   = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      mx_q    <= '0;
      my_q    <= '0;
      accx_q  <= '0;
      accy_q  <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      accx_q  <= accx_d;
      accy_q  <= accy_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign cos_out   = cos_q;
  assign sin_out   = sin_q;
  assign out_valid = vld_q;

endmodule
